// File: rtl/counter_scheduler_pkg.sv
// counter_scheduler_pkg
// Shared definitions for the counter scheduler: FSM state encoding, default
// sizing and the index-width helper used for requester indices (ptr, done_id).

package counter_scheduler_pkg;

  // Default sizing: four requesters sharing one 8-bit run counter.
  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 8;

  // Scheduler FSM: idle/arbitrate, count a run, one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a requester index; never below one bit so a single-requester
  // build still has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts at index ptr and
// walks upward, wrapping modulo N_REQ; the first pending request wins and is
// reported one-hot (all zero when nothing is pending).
// Build option: COUNTER_SCHEDULER_PRIO0_EN gives requester 0 absolute
// priority over the rotating search whenever it is pending.

module rr_arbiter
  import counter_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]        winner
);

  localparam int IW = idx_w(N_REQ);

  // Rotating priority scan from ptr, optionally overridden by requester 0.
  always_comb begin
    int            pos;
    logic [IW-1:0] idx;
    logic          found;
    // NOTE: every variable assigned in a combinational block gets a value on
    // entry; a path that leaves one unassigned would infer a latch.
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      idx = IW'(pos);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
`ifdef COUNTER_SCHEDULER_PRIO0_EN
    if (req[0]) begin
      winner    = '0;
      winner[0] = 1'b1;
    end
`else
`endif
  end

endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler
// One up-counter shared by N_REQ requesters. From IDLE a round-robin winner
// is granted the counter, its run length is latched, and the counter runs
// 0..len-1 (len 0 acts as 1). A normal finish spends one DONE cycle with a
// done pulse and the owner's index; the owner dropping its request aborts
// the run silently. Arbitration only happens in IDLE, and not on the first
// edge after reset release.
// Build option: COUNTER_SCHEDULER_PRIO0_EN makes a pending requester 0 win
// every arbitration and leaves the rotation pointer untouched on its grants.

module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      c,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*CNT_W-1:0]    len,
  output logic [N_REQ-1:0]          grant,
  output logic [CNT_W-1:0]          count,
  output logic                      busy,
  output logic                      done,
  output logic [idx_w(N_REQ)-1:0]   done_id
);

  localparam int                IW       = idx_w(N_REQ);
  localparam logic [IW-1:0]     LAST_IDX = IW'(N_REQ - 1);
  localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             armed_q;

  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic [CNT_W-1:0] win_len;
  logic [CNT_W-1:0] len_arr [N_REQ];

  // Per-requester view of the packed length bus.
  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = len[g*CNT_W +: CNT_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win_oh)
  );

  // Convert the arbiter's one-hot winner into a requester index.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx = IW'(i);
      end
    end
  end

  assign win_len = len_arr[win_idx];

  // Next-state logic: arbitration in IDLE, counting/abort in RUN, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && (|req)) begin
          state_d = RUN;
          owner_d = win_idx;
          count_d = '0;
          // A zero length still costs one counting cycle.
          len_d   = (win_len == '0) ? CNT_ONE : win_len;
`ifdef COUNTER_SCHEDULER_PRIO0_EN
          if (win_idx != '0) begin
            ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_ONE;
          end
`else
          ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_ONE;
`endif
        end
      end
      RUN: begin
        // Losing the owner's request takes precedence over completing.
        if (!req[owner_q]) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == (len_q - CNT_ONE)) begin
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, owner, counter and length registers.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // Hold off arbitration for the first edge after reset release.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Grant is the owner's one-hot bit, asserted only while a run is counting.
  always_comb begin
    grant = '0;
    if (state_q == RUN) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign done_id = done ? owner_q : '0;
  assign count   = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler
// Directed bench for counter_scheduler (N_REQ=4, CNT_W=8). A behavioural
// model tracks the current run (owner, elapsed count, length) and is compared
// with the DUT on every falling edge; directed literal checks pin the model
// and the boundary cases. Honours COUNTER_SCHEDULER_PRIO0_EN when defined.

module tb_counter_scheduler;

  localparam int NR = 4;
  localparam int CW = 8;

  logic          c;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*CW-1:0] len;
  logic [NR-1:0] grant;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [1:0]    done_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  counter_scheduler #(
    .N_REQ (NR),
    .CNT_W (CW)
  ) dut (
    .c       (c),
    .rst_n   (rst_n),
    .req     (req),
    .len     (len),
    .grant   (grant),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .done_id (done_id)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // ---------------------------------------------------------------- model
  typedef struct {
    int owner;    // -1 when no run is active
    int count;
    int len;
    bit done;
    int done_id;
    int ptr;
    bit armed;
    bit started;  // a run started on the most recent edge
    int cyc;
  } mdl_t;

  mdl_t m;
  int   log_id[$];
  int   log_cyc[$];

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.owner = -1; s.count = 0; s.len = 1; s.done = 1'b0; s.done_id = 0;
    s.ptr = 0; s.armed = 1'b0; s.started = 1'b0; s.cyc = 0;
    return s;
  endfunction

  function automatic int pick(input logic [NR-1:0] r, input int p);
`ifdef COUNTER_SCHEDULER_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic [NR-1:0] r,
                                input logic [NR*CW-1:0] l);
    mdl_t n;
    int   w;
    n = s;
    n.started = 1'b0;
    n.cyc = s.cyc + 1;
    if (s.done) begin
      n.done = 1'b0;
    end else if (s.owner >= 0) begin
      if (!r[s.owner]) begin
        n.owner = -1;
        n.count = 0;
      end else if (s.count == s.len - 1) begin
        n.done = 1'b1;
        n.done_id = s.owner;
        n.owner = -1;
      end else begin
        n.count = s.count + 1;
      end
    end else if (s.armed && r != '0) begin
      w = pick(r, s.ptr);
      n.owner = w;
      n.count = 0;
      n.len = (l[w*CW +: CW] == '0) ? 1 : int'(l[w*CW +: CW]);
      n.started = 1'b1;
`ifdef COUNTER_SCHEDULER_PRIO0_EN
      if (w != 0) n.ptr = (w + 1) % NR;
`else
      n.ptr = (w + 1) % NR;
`endif
    end
    n.armed = 1'b1;
    return n;
  endfunction

  always @(posedge c or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= step(m, req, len);
  end

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus a log of run starts.
  always @(negedge c) begin
    if (m.started) begin
      log_id.push_back(m.owner);
      log_cyc.push_back(m.cyc);
    end
    if (chk_en) begin
      check("cyc_grant", 32'(grant), (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
      check("cyc_busy", 32'(busy), 32'(m.owner >= 0));
      check("cyc_done", 32'(done), 32'(m.done));
      check("cyc_done_id", 32'(done_id), m.done ? m.done_id : 0);
      if (m.owner >= 0 || m.done) begin
        check("cyc_count", 32'(count), m.count);
      end
    end
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(negedge c);
    @(negedge c);
    rst_n = 1'b1;
  endtask

  task automatic check_ids(input string name, input int n, input int e0,
                           input int e1, input int e2, input int e3, input int e4);
    int exp_ids[5];
    exp_ids = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < n; i++) begin
      check(name, (log_id.size() > i) ? log_id[i] : -1, exp_ids[i]);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n = 1'b1;
    req   = '0;
    len   = '0;
    #2;
    rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_grant", 32'(grant), 0);
    check("reset_count", 32'(count), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);

    // Single run: len0=5.
    do_reset();
    len = {8'd0, 8'd0, 8'd0, 8'd5};
    tick();
    req = 4'b0001;
    tick();
    check("single_grant_c1", 32'(grant), 32'b0001);
    check("single_count_c1", 32'(count), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("single_count", 32'(count), i);
      check("single_grant", 32'(grant), 32'b0001);
    end
    tick();
    check("single_done", 32'(done), 1);
    check("single_done_id", 32'(done_id), 0);
    check("single_grant_done", 32'(grant), 0);
    check("single_count_hold", 32'(count), 4);
    req = '0;
    tick();
    check("single_done_1cyc", 32'(done), 0);

    // Round-robin with all requests held, len=2; first grant at second edge.
    rst_n = 1'b0;
    req = 4'b1111;
    len = {8'd2, 8'd2, 8'd2, 8'd2};
    @(negedge c);
    @(negedge c);
    rst_n = 1'b1;
    log_id.delete();
    log_cyc.delete();
    tick();
    check("rr_no_grant_edge1", 32'(grant), 0);
    tick();
    check("rr_grant_edge2", 32'(grant), 32'b0001);
    for (int i = 0; i < 17; i++) tick();
`ifdef COUNTER_SCHEDULER_PRIO0_EN
    check_ids("rr_order", 5, 0, 0, 0, 0, 0);
`else
    check_ids("rr_order", 5, 0, 1, 2, 3, 0);
`endif
    for (int i = 1; i < 5; i++) begin
      check("rr_spacing", (log_cyc.size() > i) ? log_cyc[i] - log_cyc[i-1] : -1, 4);
    end
    req = '0;
    tick();

    // Zero length on requester 2.
    do_reset();
    len = {8'd9, 8'd0, 8'd9, 8'd9};
    tick();
    req = 4'b0100;
    tick();
    check("zero_grant", 32'(grant), 32'b0100);
    check("zero_count", 32'(count), 0);
    check("zero_busy", 32'(busy), 1);
    tick();
    check("zero_done", 32'(done), 1);
    check("zero_done_id", 32'(done_id), 2);
    check("zero_grant_done", 32'(grant), 0);
    req = '0;
    tick();

    // Abort: requester 1 drops at count 3; next winner searched from ptr 2.
    do_reset();
    len = {8'd3, 8'd3, 8'd10, 8'd3};
    tick();
    req = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) tick();
    check("abort_count3", 32'(count), 3);
    req = '0;
    tick();
    check("abort_grant", 32'(grant), 0);
    check("abort_count", 32'(count), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_no_done", 32'(done), 0);
    req = 4'b1010;
    tick();
    check("abort_next_winner", 32'(grant), 32'b1000);
    req = '0;
    tick();
    tick();

    // Reset mid-run at count 7; next arbitration from ptr 0.
    do_reset();
    len = {8'd9, 8'd20, 8'd9, 8'd9};
    tick();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("rst_mid_count7", 32'(count), 7);
    rst_n = 1'b0;
    req = 4'b1100;
    #1;
    check("rst_mid_grant", 32'(grant), 0);
    check("rst_mid_count", 32'(count), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_done_id", 32'(done_id), 0);
    @(negedge c);
    rst_n = 1'b1;
    tick();
    check("rst_arm_no_grant", 32'(grant), 0);
    tick();
    check("rst_ptr0_winner", 32'(grant), 32'b0100);
    req = '0;
    tick();

    // req=1001 repeatedly with len=1, then requester 3 alone.
    do_reset();
    len = {8'd1, 8'd1, 8'd1, 8'd1};
    tick();
    log_id.delete();
    log_cyc.delete();
    req = 4'b1001;
    for (int i = 0; i < 12; i++) tick();
`ifdef COUNTER_SCHEDULER_PRIO0_EN
    check_ids("p0_order", 4, 0, 0, 0, 0, 0);
`else
    check_ids("p0_order", 4, 0, 3, 0, 3, 0);
`endif
    log_id.delete();
    log_cyc.delete();
    req = 4'b1000;
    for (int i = 0; i < 4; i++) tick();
    check("p0_req3_alone", (log_id.size() > 0) ? log_id[0] : -1, 3);
    req = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
